unidad_busqueda_pc: RTL and testbench

Program-counter and instruction-fetch sequencer for the 64-bit datapath. Holds the PC, presents it on `bus_out` to the branch-target adder (which returns `result_suma`), fetches one 32-bit instruction per PC over a req/ack instruction-memory handshake, and issues it downstream with a valid/ready handshake. The next PC is selected between PC+4 and the adder result.

---
 rtl/unidad_busqueda_pc_pkg.sv | 15 +
 rtl/unidad_busqueda_pc_sumador_pc4.sv | 14 +
 rtl/unidad_busqueda_pc.sv | 115 +++++++++++
 tb/tb_unidad_busqueda_pc.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/unidad_busqueda_pc_pkg.sv
// Shared types and constants for the PC / fetch sequencer.
// Provides the FSM state enum, instruction size and default reset PC.
package unidad_busqueda_pc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/unidad_busqueda_pc_sumador_pc4.sv
// Combinational PC + INSTR_BYTES incrementer, modulo 2^ADDR_W.
// Ports: pc_in (current PC), pc_out (pc_in + 4, wrapping).
module sumador_pc4
    import unidad_busqueda_pc_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc_out
);

    assign pc_out = pc_in + ADDR_W'(INSTR_BYTES);

endmodule

// File: rtl/unidad_busqueda_pc.sv
// Program counter and instruction fetch sequencer (IDLE/REQ/ISSUE/DRAIN).
// Ports: clk, rst_n; result_suma/branch_taken/flush select the next PC;
// imem_req/imem_addr/imem_ack/imem_rdata fetch; instr/instr_valid/
// instr_ready issue; bus_out is the PC; misalign_err flags bad targets.
module unidad_busqueda_pc
    import unidad_busqueda_pc_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 64,
    parameter int          INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  result_suma,
    input  logic               branch_taken,
    input  logic               flush,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  bus_out,
    output logic               misalign_err
);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 valid_q, valid_d;
    logic                 req_q, req_d;
    logic                 mis_q, mis_d;
    logic [ADDR_W-1:0]    pc_plus4;
    logic [ADDR_W-1:0]    target;
    logic                 target_bad;

    sumador_pc4 #(.ADDR_W(ADDR_W)) u_pc4 (
        .pc_in  (pc_q),
        .pc_out (pc_plus4)
    );

    // Targets are always word aligned; low bits only raise the flag.
    assign target     = {result_suma[ADDR_W-1:2], 2'b00};
    assign target_bad = |result_suma[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        mis_d   = 1'b0;
        if (flush) begin
            pc_d    = target;
            mis_d   = target_bad;
            valid_d = 1'b0;
            unique case (state_q)
                REQ:     state_d = imem_ack ? REQ : DRAIN;
                // The pending response is still owed unless it lands now.
                DRAIN:   state_d = imem_ack ? REQ : DRAIN;
                default: state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (valid_q && instr_ready) begin
                        pc_d    = branch_taken ? target : pc_plus4;
                        mis_d   = branch_taken && target_bad;
                        valid_d = 1'b0;
                        state_d = REQ;
                    end
                end
                DRAIN: begin
                    if (imem_ack) state_d = REQ;
                end
                default: state_d = IDLE;
            endcase
        end
        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC[ADDR_W-1:0];
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            mis_q   <= mis_d;
        end
    end

    assign bus_out      = pc_q;
    assign imem_addr    = pc_q;
    assign imem_req     = req_q;
    assign instr        = instr_q;
    assign instr_valid  = valid_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_unidad_busqueda_pc.sv
// Directed testbench for unidad_busqueda_pc.
// Zero-wait memory model plus manual ack control for delayed responses.
module tb_unidad_busqueda_pc;

    logic        clk;
    logic        rst_n;
    logic [63:0] result_suma;
    logic        branch_taken;
    logic        flush;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [63:0] bus_out;
    logic        misalign_err;

    logic        mem_auto;
    logic        ack_man;
    logic [31:0] rdata_man;

    int n_cmp;
    int n_err;

    unidad_busqueda_pc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .result_suma  (result_suma),
        .branch_taken (branch_taken),
        .flush        (flush),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .bus_out      (bus_out),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    assign imem_ack   = mem_auto ? imem_req : ack_man;
    assign imem_rdata = mem_auto ? mem_word(imem_addr) : rdata_man;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (bus_out !== 64'h0) begin n_err++; $display("FAIL rst_bus got %h want %h", bus_out, 64'h0); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", instr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL rst_mis got %b want 0", misalign_err); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL idle_to_req got %b want 1", imem_req); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            logic [63:0] a;
            a = 64'(4 * k);
            if (k != 0) step();
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== a) begin n_err++; $display("FAIL seq_req%0d got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, a); end
            n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL seq_gap%0d got %b want 0", k, instr_valid); end
            step();
            n_cmp++; if (instr_valid !== 1'b1 || instr !== mem_word(a) || bus_out !== a) begin n_err++; $display("FAIL seq_issue%0d got v=%b i=%h pc=%h want 1 %h %h", k, instr_valid, instr, bus_out, mem_word(a), a); end
        end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        result_suma  = 64'h100;
        step();
        branch_taken = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin n_err++; $display("FAIL br_target got %b %h want 1 %h", imem_req, imem_addr, 64'h100); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL br_mis got %b want 0", misalign_err); end
        step();
        step();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h104) begin n_err++; $display("FAIL br_next got %b %h want 1 %h", imem_req, imem_addr, 64'h104); end
    endtask

    task automatic test_flush_drain();
        mem_auto    = 1'b0;
        ack_man     = 1'b0;
        flush       = 1'b1;
        result_suma = 64'h200;
        step();
        flush = 1'b0;
        n_cmp++; if (imem_req !== 1'b0 || bus_out !== 64'h200) begin n_err++; $display("FAIL fl_drain got req=%b pc=%h want 0 %h", imem_req, bus_out, 64'h200); end
        step();
        step();
        n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL fl_wait got req=%b v=%b want 0 0", imem_req, instr_valid); end
        ack_man   = 1'b1;
        rdata_man = 32'hBAD0_BAD0;
        step();
        ack_man = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL fl_discard got %b want 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin n_err++; $display("FAIL fl_refetch got %b %h want 1 %h", imem_req, imem_addr, 64'h200); end
        mem_auto = 1'b1;
        step();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== mem_word(64'h200)) begin n_err++; $display("FAIL fl_issue got %b %h want 1 %h", instr_valid, instr, mem_word(64'h200)); end
    endtask

    task automatic test_stall();
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++; if (instr_valid !== 1'b1 || instr !== mem_word(64'h200) || bus_out !== 64'h200) begin n_err++; $display("FAIL stall%0d got v=%b i=%h pc=%h want 1 %h %h", k, instr_valid, instr, bus_out, mem_word(64'h200), 64'h200); end
        end
        instr_ready = 1'b1;
        step();
        n_cmp++; if (instr_valid !== 1'b0 || bus_out !== 64'h204) begin n_err++; $display("FAIL stall_accept got v=%b pc=%h want 0 %h", instr_valid, bus_out, 64'h204); end
    endtask

    task automatic test_misalign_wrap();
        step();
        branch_taken = 1'b1;
        result_suma  = 64'h103;
        step();
        branch_taken = 1'b0;
        n_cmp++; if (bus_out !== 64'h100 || misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_pulse got pc=%h m=%b want %h 1", bus_out, misalign_err, 64'h100); end
        step();
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_clear got %b want 0", misalign_err); end
        flush       = 1'b1;
        result_suma = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        flush = 1'b0;
        n_cmp++; if (bus_out !== 64'hFFFF_FFFF_FFFF_FFFC || imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_load got %h %b want fffffffffffffffc 1", bus_out, imem_req); end
        step();
        step();
        n_cmp++; if (bus_out !== 64'h0 || misalign_err !== 1'b0) begin n_err++; $display("FAIL wrap_zero got %h %b want 0 0", bus_out, misalign_err); end
    endtask

    task automatic test_reset_mid();
        step();
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL mid_issue got %b want 1", instr_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b0 || bus_out !== 64'h0 || misalign_err !== 1'b0) begin n_err++; $display("FAIL mid_async got v=%b i=%h r=%b pc=%h m=%b want all 0", instr_valid, instr, imem_req, bus_out, misalign_err); end
        mem_auto  = 1'b0;
        ack_man   = 1'b1;
        rdata_man = 32'hDEAD_BEEF;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        ack_man = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h0) begin n_err++; $display("FAIL mid_restart got v=%b r=%b a=%h want 0 1 0", instr_valid, imem_req, imem_addr); end
        mem_auto = 1'b1;
        step();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== mem_word(64'h0)) begin n_err++; $display("FAIL mid_fetch got %b %h want 1 %h", instr_valid, instr, mem_word(64'h0)); end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        result_suma  = 64'h0;
        branch_taken = 1'b0;
        flush        = 1'b0;
        instr_ready  = 1'b1;
        mem_auto     = 1'b1;
        ack_man      = 1'b0;
        rdata_man    = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_flush_drain();
        test_stall();
        test_misalign_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
